seq_div16by8: RTL and testbench

- Sequential restoring divider: 16-bit dividend / 8-bit divisor, giving a 16-bit quotient and an 8-bit remainder.
- It is the inverse datapath of the 8x8 Dadda multiplier (product P = A*B).
- Used to recover A from (P, B) and to check multiplier results in-system.
- Fixed-latency start/done handshake, one quotient bit per clock.

---
 rtl/seq_div16by8.sv | 125 ++++++++++++
 tb/tb_seq_div16by8.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_div16by8.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seq_div16by8: restoring divider, 16/8 -> 16-bit quotient, 8-bit rem    |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module seq_div16by8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          ovf,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   prem_q, prem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          ovf_q, ovf_d;
  logic          dbz_q, dbz_d;

  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;
  logic          dvs_zero;
  logic          ge;
  logic [VW:0]   prem_nxt;
  logic [DW-1:0] quo_nxt;

  always_comb begin
    shifted  = {prem_q, dvd_q[DW-1]};
    trial    = shifted - {2'b00, dvs_q};
    dvs_zero = (dvs_q == '0);
    // A zero divisor lets the partial remainder grow past 9 bits' sign range,
    // so the subtraction sign is ignored and every quotient bit is forced to 1.
    ge       = ~trial[VW+1] | dvs_zero;
    prem_nxt = ge ? trial[VW:0] : shifted[VW:0];
    quo_nxt  = {dvd_q[DW-2:0], ge};

    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          prem_d  = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        dvd_d  = quo_nxt;
        prem_d = prem_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          quotient_d  = quo_nxt;
          remainder_d = prem_nxt[VW-1:0];
          ovf_d       = ~dvs_zero & (|quo_nxt[DW-1:VW]);
          dbz_d       = dvs_zero;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
    end
  end

  assign ready       = (state_q == ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign ovf         = ovf_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_div16by8.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_seq_div16by8: directed and random checks for seq_div16by8           |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_seq_div16by8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        ready, done, ovf, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int n_checks = 0;
  int n_errors = 0;

  seq_div16by8 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .ovf         (ovf),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the cycle after done, where the DUT is idle again.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er,
                       input logic eovf, input logic edbz, input bit interfere);
    int lat;
    int bad_ready;
    int unstable;
    logic [15:0] q_hold;
    logic [7:0]  r_hold;
    chk("ready_before_start", 32'(ready), 32'd1);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + 8'd1;
    lat       = 1;
    bad_ready = 0;
    unstable  = 0;
    q_hold    = quotient;
    r_hold    = remainder;
    while (!done && lat < 40) begin
      if (ready) bad_ready++;
      if (quotient !== q_hold || remainder !== r_hold) unstable++;
      if (interfere && lat == 5) begin
        start    = 1'b1;
        dividend = 16'h0101;
        divisor  = 8'h07;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'd17);
    chk("ready_low_run", 32'(bad_ready), 32'd0);
    chk("results_stable_run", 32'(unstable), 32'd0);
    chk("ready_in_done", 32'(ready), 32'd0);
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("ovf", 32'(ovf), 32'(eovf));
    chk("div_by_zero", 32'(div_by_zero), 32'(edbz));
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("quotient_hold", 32'(quotient), 32'(eq));
  endtask

  initial begin
    logic [15:0] a, eq;
    logic [7:0]  b, er;
    int dones;

    repeat (3) step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_ovf_dbz", 32'({ovf, div_by_zero}), 32'd0);
    rst = 1'b0;
    step();

    do_op(16'h00F0, 8'h03, 16'h0050, 8'h00, 1'b0, 1'b0, 1'b0);
    // Back-to-back: each start lands in the cycle right after done.
    do_op(16'h0EF1, 8'h0F, 16'h00FF, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op(16'hFD02, 8'hFF, 16'h00FE, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op(16'h03A8, 8'h34, 16'h0012, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op(16'h0110, 8'h02, 16'h0088, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op(16'h3A1C, 8'h55, 16'h00AF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b0, 1'b1, 1'b0);
    do_op(16'h0064, 8'h07, 16'h000E, 8'h02, 1'b0, 1'b0, 1'b1);

    // Abort an operation mid-RUN with reset.
    dividend = 16'h5555;
    divisor  = 8'h03;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_ovf_dbz", 32'({ovf, div_by_zero}), 32'd0);
    dones = 0;
    repeat (30) begin
      if (done) dones++;
      step();
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 8'($urandom);
      if (i == 0) b = 8'h01;
      if (i == 1) b = 8'hFF;
      if (i == 2) a = 16'h0000;
      if (i == 3) begin a = 16'hFFFF; b = 8'hFF; end
      if (b == 8'h00) begin
        eq = 16'hFFFF;
        er = a[7:0];
      end else begin
        eq = a / {8'h00, b};
        er = 8'(a % {8'h00, b});
      end
      do_op(a, b, eq, er, (b != 8'h00) && (eq > 16'd255), b == 8'h00, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
